universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/universal_shift_register.sv | 99 +++++++++
 tb/tb_universal_shift_register.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// WIDTH-bit register that holds, loads, shifts, rotates, clears or complements
// its contents once per rising clock edge, qualified by a clock enable.
//
// Parameters
//   WIDTH        register width in bits (must be >= 2)
//   RESET_VALUE  value forced into q while rst is high
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   en     in   1      clock enable; 0 holds q whatever the mode
//   mode   in   3      operation select (see mode_e)
//   d      in   WIDTH  parallel load data
//   sinl   in   1      serial bit entering at the MSB on shift right
//   sinr   in   1      serial bit entering at the LSB on shift left
//   q      out  WIDTH  register state
//   qb     out  WIDTH  bitwise complement of q
//   soutl  out  1      q[WIDTH-1], the bit a left shift/rotate pushes out
//   soutr  out  1      q[0], the bit a right shift/rotate pushes out
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sinl,
  input  logic             sinr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             soutl,
  output logic             soutr
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_INV  = 3'b111
  } mode_e;

  // Shifts and rotates slice q[WIDTH-2:0] / q[WIDTH-1:1], which only make
  // sense for at least two bits.
  if (WIDTH < 2) begin : g_width_check
    $error("universal_shift_register: WIDTH must be >= 2");
  end

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_next;

  assign mode_sel = mode_e'(mode);

  // Next-state selection. Serial inputs appear only in the two shift arms, so
  // they cannot disturb any other operation.
  always_comb begin
    // NOTE: q_next is assigned before the case so every path drives it; a
    // missing branch would otherwise infer a latch.
    q_next = q;
    case (mode_sel)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sinr};
      MODE_SHR:  q_next = {sinl, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      MODE_INV:  q_next = ~q;
      default:   q_next = q;
    endcase
  end

  // State register: WIDTH flops, reset asynchronously, enabled by en.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment so every flop samples the pre-edge q;
    // blocking here would let rotate/shift read already-updated bits.
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= q_next;
    end
  end

  // Derived outputs are pure decodes of the flops, so qb never lags q and the
  // shifted-out bit is visible before the edge that discards it.
  assign qb    = ~q;
  assign soutl = q[WIDTH-1];
  assign soutr = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_register
//
// Directed bench for universal_shift_register at WIDTH=4. dut0 uses
// RESET_VALUE=4'b0000 and carries most sequences; dut1 uses RESET_VALUE=4'b1100
// and covers reset held across load edges followed by release.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_universal_shift_register;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst0, rst1;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sinl, sinr;
  logic [W-1:0] q0, qb0, q1, qb1;
  logic         soutl0, soutr0, soutl1, soutr1;

  int checks = 0;
  int errors = 0;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(4'b0000)) dut0 (
    .clk(clk), .rst(rst0), .en(en), .mode(mode), .d(d),
    .sinl(sinl), .sinr(sinr),
    .q(q0), .qb(qb0), .soutl(soutl0), .soutr(soutr0)
  );

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(4'b1100)) dut1 (
    .clk(clk), .rst(rst1), .en(en), .mode(mode), .d(d),
    .sinl(sinl), .sinr(sinr),
    .q(q1), .qb(qb1), .soutl(soutl1), .soutr(soutr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [W-1:0] v);
    en   = 1'b1;
    mode = 3'b001;
    d    = v;
    step();
    check("load", 8'(q0), 8'(v));
  endtask

  logic [W-1:0] exp_q [4];
  logic         sr_in [4];
  logic         so_l  [4];

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    en   = 1'b1;
    mode = 3'b001;
    d    = 4'b0011;
    sinl = 1'b0;
    sinr = 1'b0;

    // Asynchronous reset value before any clock edge.
    #1;
    check("rst_q0_no_clk",  8'(q0),  8'(4'b0000));
    check("rst_qb0_no_clk", 8'(qb0), 8'(4'b1111));
    check("rst_q1_no_clk",  8'(q1),  8'(4'b1100));
    check("rst_qb1_no_clk", 8'(qb1), 8'(4'b0011));

    // Reset held across two load edges on dut1, then release.
    step();
    step();
    check("rst1_hold_q",  8'(q1),  8'(4'b1100));
    check("rst1_hold_qb", 8'(qb1), 8'(4'b0011));
    rst1 = 1'b0;
    step();
    check("rst1_first_load", 8'(q1), 8'(4'b0011));

    // Mid-cycle reset pulse on dut0 holding 1011.
    rst0 = 1'b0;
    load0(4'b1011);
    #2;
    rst0 = 1'b1;
    #1;
    check("rst_async_q",  8'(q0),  8'(4'b0000));
    check("rst_async_qb", 8'(qb0), 8'(4'b1111));
    step();
    check("rst_overrides_load", 8'(q0), 8'(4'b0000));
    rst0 = 1'b0;
    step();
    check("post_rst_first_load", 8'(q0), 8'(4'b1011));

    // Shift left with SinR = 1,0,1,1; SinL driven opposite and must be ignored.
    load0(4'b1001);
    exp_q = '{4'b0011, 4'b0110, 4'b1101, 4'b1011};
    sr_in = '{1'b1, 1'b0, 1'b1, 1'b1};
    so_l  = '{1'b1, 1'b0, 1'b0, 1'b1};
    mode  = 3'b010;
    for (int i = 0; i < 4; i++) begin
      sinr = sr_in[i];
      sinl = ~sr_in[i];
      #1;
      check($sformatf("shl_soutl_%0d", i), 8'(soutl0), 8'(so_l[i]));
      step();
      check($sformatf("shl_q_%0d", i), 8'(q0), 8'(exp_q[i]));
    end

    // Rotate right four times, then rotate left once; serial inputs high.
    sinl = 1'b1;
    sinr = 1'b1;
    load0(4'b0001);
    exp_q = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    mode  = 3'b101;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ror_q_%0d", i), 8'(q0), 8'(exp_q[i]));
    end
    check("ror_soutr", 8'(soutr0), 8'(1'b1));
    mode = 3'b100;
    step();
    check("rol_q", 8'(q0), 8'(4'b0010));

    // En=0 holds across every mode.
    load0(4'b0110);
    en = 1'b0;
    d  = 4'b1111;
    for (int m = 1; m < 8; m++) begin
      mode = 3'(m);
      step();
      check($sformatf("en0_mode%0d", m), 8'(q0), 8'(4'b0110));
    end

    // Inputs changed between edges do not matter; only the edge sample does.
    en   = 1'b1;
    mode = 3'b001;
    #2;
    mode = 3'b000;
    step();
    check("between_edge_change", 8'(q0), 8'(4'b0110));

    // Complement, sync clear, shift right with SinL=1.
    load0(4'b0101);
    mode = 3'b111;
    step();
    check("inv_q",  8'(q0),  8'(4'b1010));
    check("inv_qb", 8'(qb0), 8'(4'b0101));
    mode = 3'b110;
    step();
    check("clr_q", 8'(q0), 8'(4'b0000));
    mode = 3'b011;
    sinl = 1'b1;
    sinr = 1'b0;
    step();
    check("shr_q",     8'(q0),     8'(4'b1000));
    check("shr_soutl", 8'(soutl0), 8'(1'b1));
    check("shr_soutr", 8'(soutr0), 8'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
